// File: rtl/l1_l2_arbiter_pkg.sv
// l1_l2_arbiter_pkg
// Shared definitions for the L1/L2 shared-port arbiter: FSM state encoding,
// field widths, the writeback record layout {addr, tag, data}, the response
// watchdog limit and helpers that split a writeback record.
package l1_l2_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_REQ  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   localparam int ADDR_W = 3;
   localparam int TAG_W  = 8;
   localparam int DATA_W = 3;
   localparam int WORD_W = TAG_W + DATA_W;   // {tag, data}
   localparam int WB_W   = ADDR_W + WORD_W;  // {addr, tag, data}

   // Writeback record slice positions
   localparam int WB_ADDR_HI = WB_W - 1;
   localparam int WB_ADDR_LO = WORD_W;
   localparam int WB_WORD_HI = WORD_W - 1;
   localparam int WB_WORD_LO = 0;

   // L2 response watchdog limit (cycles) and its counter width
   localparam int TIMEOUT  = 15;
   localparam int TO_CNT_W = $clog2(TIMEOUT + 1);

   function automatic logic [ADDR_W-1:0] wb_addr(input logic [WB_W-1:0] rec);
      return rec[WB_ADDR_HI:WB_ADDR_LO];
   endfunction

   function automatic logic [WORD_W-1:0] wb_word(input logic [WB_W-1:0] rec);
      return rec[WB_WORD_HI:WB_WORD_LO];
   endfunction

endpackage

// File: rtl/l1_wb_buffer.sv
// l1_wb_buffer
// One-entry writeback buffer for a single L1.
//   clock, reset   : clock and synchronous active-high reset
//   wback          : one-cycle pulse, wbackdata is to be buffered
//   wbackdata      : writeback record {addr, tag, data}
//   drain          : the buffered record has been consumed (written or aborted)
//   full           : buffer holds a valid record
//   data           : buffered record
//   ovf            : sticky, a record arrived while the buffer was occupied
module l1_wb_buffer
   import l1_l2_arbiter_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            wback,
   input  logic [WB_W-1:0] wbackdata,
   input  logic            drain,
   output logic            full,
   output logic [WB_W-1:0] data,
   output logic            ovf
);

   logic            full_reg;
   logic [WB_W-1:0] data_reg;
   logic            ovf_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         full_reg <= 1'b0;
         data_reg <= '0;
         ovf_reg  <= 1'b0;
      end else if (drain) begin
         // A record arriving on the drain cycle takes the freed slot at once
         if (wback) begin
            data_reg <= wbackdata;
         end else begin
            full_reg <= 1'b0;
         end
      end else if (wback) begin
         if (!full_reg) begin
            data_reg <= wbackdata;
            full_reg <= 1'b1;
         end else begin
            ovf_reg  <= 1'b1;
         end
      end
   end

   assign full = full_reg;
   assign data = data_reg;
   assign ovf  = ovf_reg;

endmodule

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter
// Shares one L2 request port between two L1 caches. Requests are granted
// round-robin; a requester's buffered writeback is always sent to L2 ahead
// of that requester's fetch. With no request pending, buffered writebacks
// are drained on their own.
// Optional feature macro: ARB_TIMEOUT_EN adds an L2 response watchdog that
// aborts a transaction after TIMEOUT wait cycles and reports resp_err.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   req/write/addr/data 0,1      : L1 request (held until resp)
//   wback/wbackdata 0,1          : writeback pulse and record
//   wbfull0/1                    : writeback buffer occupied
//   resp0/1, fill, fill_miss     : completion pulse and returned data
//   resp_err                     : transaction aborted by the watchdog
//   l2_valid/write/wb/addr/data  : L2 request, held stable until l2_ready
//   l2_ready, l2_miss, l2_rdata  : L2 completion and read data
//   err_ovf                      : sticky writeback overflow
//   busy                         : FSM not idle
module l1_l2_arbiter
   import l1_l2_arbiter_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              write0,
   input  logic              write1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [WORD_W-1:0] data0,
   input  logic [WORD_W-1:0] data1,
   input  logic              wback0,
   input  logic              wback1,
   input  logic [WB_W-1:0]   wbackdata0,
   input  logic [WB_W-1:0]   wbackdata1,
   output logic              wbfull0,
   output logic              wbfull1,
   output logic              resp0,
   output logic              resp1,
   output logic [WORD_W-1:0] fill,
   output logic              fill_miss,
   output logic              resp_err,
   output logic              l2_valid,
   output logic              l2_write,
   output logic              l2_wb,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [WORD_W-1:0] l2_data,
   input  logic              l2_ready,
   input  logic              l2_miss,
   input  logic [WORD_W-1:0] l2_rdata,
   output logic              err_ovf,
   output logic              busy
);

   state_t            state_reg;
   logic              rr_reg;
   logic              gid_reg;     // requester that receives resp
   logic              wb_id_reg;   // buffer being written back
   logic              solo_reg;    // writeback is a standalone drain
   logic              wr_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [WORD_W-1:0] data_reg;
   logic              l2_valid_reg, l2_write_reg, l2_wb_reg;
   logic [ADDR_W-1:0] l2_addr_reg;
   logic [WORD_W-1:0] l2_data_reg;
   logic [1:0]        resp_reg;
   logic [WORD_W-1:0] fill_reg;
   logic              fill_miss_reg;
   logic              timeout_hit;

   logic [1:0]        wback_v, buf_full, buf_drain, buf_ovf;
   logic [WB_W-1:0]   wbd_v    [2];
   logic [WB_W-1:0]   buf_data [2];

   assign wback_v  = {wback1, wback0};
   assign wbd_v[0] = wbackdata0;
   assign wbd_v[1] = wbackdata1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_buf
         assign buf_drain[gi] = (state_reg == ST_WB) && (wb_id_reg == 1'(gi)) &&
                                (l2_ready || timeout_hit);
         l1_wb_buffer u_buf (
            .clock     (clock),
            .reset     (reset),
            .wback     (wback_v[gi]),
            .wbackdata (wbd_v[gi]),
            .drain     (buf_drain[gi]),
            .full      (buf_full[gi]),
            .data      (buf_data[gi]),
            .ovf       (buf_ovf[gi])
         );
      end
   endgenerate

   // Grant: the favoured requester wins a tie; drains follow the same pointer
   logic              grant_id, drain_id;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [WORD_W-1:0] req_data;

   always_comb begin
      grant_id  = (req0 && req1) ? rr_reg : req1;
      drain_id  = buf_full[rr_reg] ? rr_reg : ~rr_reg;
      req_write = grant_id ? write1 : write0;
      req_addr  = grant_id ? addr1  : addr0;
      req_data  = grant_id ? data1  : data0;
   end

`ifdef ARB_TIMEOUT_EN
   logic [TO_CNT_W-1:0] cnt_reg;
   logic                resp_err_reg;
   logic                waiting;

   assign waiting     = ((state_reg == ST_WB) || (state_reg == ST_REQ)) && !l2_ready;
   assign timeout_hit = waiting && (cnt_reg == TO_CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset || !waiting) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         rr_reg        <= 1'b0;
         gid_reg       <= 1'b0;
         wb_id_reg     <= 1'b0;
         solo_reg      <= 1'b0;
         wr_reg        <= 1'b0;
         addr_reg      <= '0;
         data_reg      <= '0;
         l2_valid_reg  <= 1'b0;
         l2_write_reg  <= 1'b0;
         l2_wb_reg     <= 1'b0;
         l2_addr_reg   <= '0;
         l2_data_reg   <= '0;
         resp_reg      <= '0;
         fill_reg      <= '0;
         fill_miss_reg <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         resp_err_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (req0 || req1) begin
                  gid_reg      <= grant_id;
                  wb_id_reg    <= grant_id;
                  solo_reg     <= 1'b0;
                  wr_reg       <= req_write;
                  addr_reg     <= req_addr;
                  data_reg     <= req_data;
                  l2_valid_reg <= 1'b1;
                  if (buf_full[grant_id]) begin
                     state_reg    <= ST_WB;
                     l2_write_reg <= 1'b1;
                     l2_wb_reg    <= 1'b1;
                     l2_addr_reg  <= wb_addr(buf_data[grant_id]);
                     l2_data_reg  <= wb_word(buf_data[grant_id]);
                  end else begin
                     state_reg    <= ST_REQ;
                     l2_write_reg <= req_write;
                     l2_wb_reg    <= 1'b0;
                     l2_addr_reg  <= req_addr;
                     l2_data_reg  <= req_data;
                  end
               end else if (|buf_full) begin
                  state_reg    <= ST_WB;
                  gid_reg      <= drain_id;
                  wb_id_reg    <= drain_id;
                  solo_reg     <= 1'b1;
                  l2_valid_reg <= 1'b1;
                  l2_write_reg <= 1'b1;
                  l2_wb_reg    <= 1'b1;
                  l2_addr_reg  <= wb_addr(buf_data[drain_id]);
                  l2_data_reg  <= wb_word(buf_data[drain_id]);
               end
            end
            ST_WB: begin
               if (l2_ready) begin
                  if (solo_reg) begin
                     state_reg    <= ST_IDLE;
                     l2_valid_reg <= 1'b0;
                     l2_write_reg <= 1'b0;
                     l2_wb_reg    <= 1'b0;
                  end else begin
                     state_reg    <= ST_REQ;
                     l2_write_reg <= wr_reg;
                     l2_wb_reg    <= 1'b0;
                     l2_addr_reg  <= addr_reg;
                     l2_data_reg  <= data_reg;
                  end
               end
`ifdef ARB_TIMEOUT_EN
               else if (timeout_hit) begin
                  // Aborted writeback is reported to the buffer's owner
                  state_reg           <= ST_RESP;
                  gid_reg             <= wb_id_reg;
                  resp_reg[wb_id_reg] <= 1'b1;
                  resp_err_reg        <= 1'b1;
                  fill_reg            <= '0;
                  fill_miss_reg       <= 1'b0;
                  l2_valid_reg        <= 1'b0;
                  l2_write_reg        <= 1'b0;
                  l2_wb_reg           <= 1'b0;
               end
`endif
            end
            ST_REQ: begin
               if (l2_ready) begin
                  state_reg         <= ST_RESP;
                  resp_reg[gid_reg] <= 1'b1;
                  fill_reg          <= l2_rdata;
                  fill_miss_reg     <= l2_miss;
                  l2_valid_reg      <= 1'b0;
                  l2_write_reg      <= 1'b0;
                  l2_wb_reg         <= 1'b0;
               end
`ifdef ARB_TIMEOUT_EN
               else if (timeout_hit) begin
                  state_reg         <= ST_RESP;
                  resp_reg[gid_reg] <= 1'b1;
                  resp_err_reg      <= 1'b1;
                  fill_reg          <= '0;
                  fill_miss_reg     <= 1'b0;
                  l2_valid_reg      <= 1'b0;
                  l2_write_reg      <= 1'b0;
                  l2_wb_reg         <= 1'b0;
               end
`endif
            end
            ST_RESP: begin
               state_reg <= ST_IDLE;
               resp_reg  <= '0;
               rr_reg    <= ~gid_reg;
`ifdef ARB_TIMEOUT_EN
               resp_err_reg <= 1'b0;
`endif
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_TIMEOUT_EN
   assign resp_err = resp_err_reg;
`else
   assign resp_err = 1'b0;
`endif

   assign wbfull0   = buf_full[0];
   assign wbfull1   = buf_full[1];
   assign resp0     = resp_reg[0];
   assign resp1     = resp_reg[1];
   assign fill      = fill_reg;
   assign fill_miss = fill_miss_reg;
   assign l2_valid  = l2_valid_reg;
   assign l2_write  = l2_write_reg;
   assign l2_wb     = l2_wb_reg;
   assign l2_addr   = l2_addr_reg;
   assign l2_data   = l2_data_reg;
   assign err_ovf   = |buf_ovf;
   assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter
// Directed bench for l1_l2_arbiter: reset state, single fetch latency,
// round-robin order, writeback-before-fetch, overflow, mid-transaction
// reset and (with ARB_TIMEOUT_EN) the response watchdog.
module tb_l1_l2_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, req1, write0, write1;
   logic [2:0]  addr0, addr1;
   logic [10:0] data0, data1;
   logic        wback0, wback1;
   logic [13:0] wbackdata0, wbackdata1;
   logic        wbfull0, wbfull1, resp0, resp1;
   logic [10:0] fill;
   logic        fill_miss, resp_err;
   logic        l2_valid, l2_write, l2_wb;
   logic [2:0]  l2_addr;
   logic [10:0] l2_data;
   logic        l2_ready, l2_miss;
   logic [10:0] l2_rdata;
   logic        err_ovf, busy;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   l1_l2_arbiter dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .write0(write0), .write1(write1),
      .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
      .wback0(wback0), .wback1(wback1),
      .wbackdata0(wbackdata0), .wbackdata1(wbackdata1),
      .wbfull0(wbfull0), .wbfull1(wbfull1),
      .resp0(resp0), .resp1(resp1), .fill(fill), .fill_miss(fill_miss),
      .resp_err(resp_err),
      .l2_valid(l2_valid), .l2_write(l2_write), .l2_wb(l2_wb),
      .l2_addr(l2_addr), .l2_data(l2_data),
      .l2_ready(l2_ready), .l2_miss(l2_miss), .l2_rdata(l2_rdata),
      .err_ovf(err_ovf), .busy(busy)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Called in a REQ cycle; completes the fetch and returns in the idle cycle after resp
   task automatic expect_fetch(input string tag, input int id, input logic [2:0] a,
                               input logic w, input logic [10:0] d,
                               input logic [10:0] rd, input logic m);
      check({tag, " l2_valid"}, 16'(l2_valid), 16'd1);
      check({tag, " l2_wb"},    16'(l2_wb),    16'd0);
      check({tag, " l2_write"}, 16'(l2_write), 16'(w));
      check({tag, " l2_addr"},  16'(l2_addr),  16'(a));
      check({tag, " l2_data"},  16'(l2_data),  16'(d));
      l2_rdata = rd;
      l2_miss  = m;
      l2_ready = 1'b1;
      tick();
      check({tag, " resp0"},     16'(resp0),     16'(id == 0));
      check({tag, " resp1"},     16'(resp1),     16'(id == 1));
      check({tag, " fill"},      16'(fill),      16'(rd));
      check({tag, " fill_miss"}, 16'(fill_miss), 16'(m));
      check({tag, " resp_err"},  16'(resp_err),  16'd0);
      if (id == 0) req0 = 1'b0; else req1 = 1'b0;
      tick();
      check({tag, " resp done"}, 16'({resp1, resp0}), 16'd0);
      $display("txn %s: id=%0d addr=%b fill=%h miss=%0d", tag, id, a, fill, fill_miss);
   endtask

   initial begin
      req0 = 0; req1 = 0; write0 = 0; write1 = 0;
      addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
      wback0 = 0; wback1 = 0; wbackdata0 = 0; wbackdata1 = 0;
      l2_ready = 0; l2_miss = 0; l2_rdata = 0;
      do_reset();

      // Reset state
      check("rst l2_valid", 16'(l2_valid), 16'd0);
      check("rst busy",     16'(busy),     16'd0);
      check("rst wbfull",   16'({wbfull1, wbfull0}), 16'd0);
      check("rst resp",     16'({resp1, resp0}), 16'd0);
      check("rst fill",     16'(fill), 16'd0);
      check("rst err_ovf",  16'(err_ovf), 16'd0);
      check("rst resp_err", 16'(resp_err), 16'd0);
      $display("txn reset: checked");

      // Single read, minimum latency
      req0 = 1; write0 = 0; addr0 = 3'b010; data0 = 11'h64C; l2_ready = 1;
      tick();
      check("t1 busy", 16'(busy), 16'd1);
      expect_fetch("t1", 0, 3'b010, 1'b0, 11'h64C, 11'h2A5, 1'b1);
      check("t1 fill hold", 16'(fill), 16'h2A5);
      check("t1 idle", 16'(busy), 16'd0);

      // Simultaneous requests from reset: req0 first, then req1
      do_reset();
      req0 = 1; write0 = 1; addr0 = 3'b001; data0 = 11'h111;
      req1 = 1; write1 = 0; addr1 = 3'b101; data1 = 11'h222;
      tick();
      expect_fetch("t2a", 0, 3'b001, 1'b1, 11'h111, 11'h0F0, 1'b0);
      tick();
      expect_fetch("t2b", 1, 3'b101, 1'b0, 11'h222, 11'h1E1, 1'b1);
      // rr back at 0: req0 alone moves it to 1, then a tie goes to req1
      req0 = 1; addr0 = 3'b011; data0 = 11'h333; write0 = 0;
      tick();
      expect_fetch("t2c", 0, 3'b011, 1'b0, 11'h333, 11'h044, 1'b0);
      req0 = 1; req1 = 1; addr0 = 3'b100; addr1 = 3'b111; data1 = 11'h555;
      tick();
      expect_fetch("t2d", 1, 3'b111, 1'b0, 11'h555, 11'h777, 1'b0);
      tick();
      expect_fetch("t2e", 0, 3'b100, 1'b0, 11'h333, 11'h123, 1'b1);

      // Writeback precedes the same requester's fetch
      l2_ready = 0;
      wback1 = 1; wbackdata1 = 14'b11001110110011;
      tick();
      wback1 = 0;
      check("t3 wbfull1 load", 16'(wbfull1), 16'd1);
      req1 = 1; write1 = 0; addr1 = 3'b001; data1 = 11'h0AA;
      tick();
      check("t3 wb valid", 16'(l2_valid), 16'd1);
      check("t3 wb flag",  16'(l2_wb),    16'd1);
      check("t3 wb write", 16'(l2_write), 16'd1);
      check("t3 wb addr",  16'(l2_addr),  16'h6);
      check("t3 wb data",  16'(l2_data),  16'h3B3);
      tick();
      check("t3 hold wb",   16'(l2_wb),   16'd1);
      check("t3 hold addr", 16'(l2_addr), 16'h6);
      check("t3 hold full", 16'(wbfull1), 16'd1);
      l2_ready = 1;
      tick();
      check("t3 wbfull1 clr", 16'(wbfull1), 16'd0);
      expect_fetch("t3", 1, 3'b001, 1'b0, 11'h0AA, 11'h5A5, 1'b0);

      // Overflow: second record dropped while the first is still buffered
      l2_ready = 0;
      wback0 = 1; wbackdata0 = {3'b101, 11'h1C3};
      tick();
      check("t4 wbfull0", 16'(wbfull0), 16'd1);
      check("t4 no ovf",  16'(err_ovf), 16'd0);
      wbackdata0 = {3'b010, 11'h7FF};
      tick();
      wback0 = 0;
      check("t4 ovf set",    16'(err_ovf), 16'd1);
      check("t4 drain wb",   16'(l2_wb),   16'd1);
      check("t4 drain addr", 16'(l2_addr), 16'h5);
      check("t4 drain data", 16'(l2_data), 16'h1C3);
      l2_ready = 1;
      tick();
      check("t4 drained", 16'(wbfull0), 16'd0);
      check("t4 idle",    16'(busy),    16'd0);
      tick();
      check("t4 ovf sticky", 16'(err_ovf), 16'd1);
      $display("txn t4: overflow err_ovf=%0d", err_ovf);

      // Reset in the middle of a fetch
      l2_ready = 0;
      req0 = 1; addr0 = 3'b110; data0 = 11'h00F;
      wback1 = 1; wbackdata1 = {3'b011, 11'h222};
      tick();
      wback1 = 0;
      check("t5 req valid", 16'(l2_valid), 16'd1);
      check("t5 wbfull1",   16'(wbfull1),  16'd1);
      reset = 1; req0 = 0;
      tick();
      reset = 0;
      check("t5 l2_valid", 16'(l2_valid), 16'd0);
      check("t5 busy",     16'(busy),     16'd0);
      check("t5 wbfull",   16'({wbfull1, wbfull0}), 16'd0);
      check("t5 ovf clr",  16'(err_ovf),  16'd0);
      $display("txn t5: reset mid-transaction");

`ifdef ARB_TIMEOUT_EN
      // Watchdog: 15 wait cycles, then aborted resp
      l2_ready = 0; l2_rdata = 11'h7AB; l2_miss = 1;
      req0 = 1; addr0 = 3'b011;
      tick();
      for (int i = 1; i < 15; i++) tick();
      check("t6 still waiting", 16'({l2_valid, resp0}), 16'b10);
      tick();
      check("t6 resp0",     16'(resp0),     16'd1);
      check("t6 resp_err",  16'(resp_err),  16'd1);
      check("t6 fill",      16'(fill),      16'd0);
      check("t6 fill_miss", 16'(fill_miss), 16'd0);
      check("t6 l2_valid",  16'(l2_valid),  16'd0);
      req0 = 0;
      tick();
      check("t6 err clr", 16'(resp_err), 16'd0);
      $display("txn t6: timeout abort");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
